fp2int_unit: RTL and testbench



---
 rtl/fp2int_unit.sv | 163 ++++++++++++++++
 tb/tb_fp2int_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp2int_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp2int_unit : sequential FP32 -> INT32 converter (valid/ready, 1-bit/cycle
// align). FP2INT_RNE_EN selects round-to-nearest-even, else truncate. Rev 1.0
// ----------------------------------------------------------------------------
module fp2int_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_32_a,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_32_int,
  output logic        o_ov_flag,
  output logic        o_nx_flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [22:0] mant_q, mant_d;
  logic [55:0] w_q, w_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        ov_q, ov_d, nx_q, nx_d, valid_q, valid_d;

  logic        w_in_range;
  logic [31:0] w_int, w_mag, w_rnd_res;
  logic        w_g, w_s, w_inc, w_rnd_ov, w_rnd_nx;

  assign w_in_range = (i_32_a[30:23] >= 8'd127) && (i_32_a[30:23] <= 8'd157);

  // Rounding of the aligned significand; exp==126 is 0.1xxx, so INT=0 and G=1.
  always_comb begin
    w_int     = w_q[55:24];
    w_g       = w_q[23];
    w_s       = |w_q[22:0];
    if (exp_q == 8'd126) begin
      w_int = 32'd0;
      w_g   = 1'b1;
      w_s   = |mant_q;
    end
`ifdef FP2INT_RNE_EN
    w_inc     = w_g & (w_s | w_int[0]);
`else
    w_inc     = 1'b0;
`endif
    w_mag     = w_int + {31'd0, w_inc};
    w_rnd_res = 32'd0;
    w_rnd_ov  = 1'b0;
    w_rnd_nx  = 1'b0;
    if (exp_q == 8'd255 && mant_q != 23'd0) begin
      w_rnd_res = 32'h7FFF_FFFF;
      w_rnd_ov  = 1'b1;
    end else if (exp_q >= 8'd158) begin
      if (sign_q && exp_q == 8'd158 && mant_q == 23'd0) begin
        w_rnd_res = 32'h8000_0000;
      end else begin
        w_rnd_res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_rnd_ov  = 1'b1;
      end
    end else if (exp_q >= 8'd126) begin
      if (!sign_q && w_mag[31]) begin
        w_rnd_res = 32'h7FFF_FFFF;
        w_rnd_ov  = 1'b1;
      end else begin
        w_rnd_res = sign_q ? (~w_mag + 32'd1) : w_mag;
        w_rnd_nx  = w_g | w_s;
      end
    end else if (exp_q == 8'd0) begin
      w_rnd_nx  = |mant_q;
    end else begin
      w_rnd_nx  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ov_d    = ov_q;
    nx_d    = nx_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          sign_d  = i_32_a[31];
          exp_d   = i_32_a[30:23];
          mant_d  = i_32_a[22:0];
          w_d     = {31'd0, 1'b1, i_32_a[22:0], 1'b0};
          // exp-127 modulo 32 equals exp+1 modulo 32
          cnt_d   = w_in_range ? (i_32_a[27:23] + 5'd1) : 5'd0;
          state_d = (cnt_d != 5'd0) ? S_SHIFT : S_ROUND;
        end
      end
      S_SHIFT: begin
        w_d   = {w_q[54:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_ROUND;
      end
      S_ROUND: begin
        res_d   = w_rnd_res;
        ov_d    = w_rnd_ov;
        nx_d    = w_rnd_nx;
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= 8'd0;
      mant_q  <= 23'd0;
      w_q     <= 56'd0;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
      ov_q    <= 1'b0;
      nx_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      nx_q    <= nx_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_valid   = valid_q;
  assign o_32_int  = res_q;
  assign o_ov_flag = ov_q;
  assign o_nx_flag = nx_q;

endmodule
`default_nettype wire

// File: tb/tb_fp2int_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fp2int_unit : directed + randomized self-checking bench for fp2int_unit.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fp2int_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_32_a = 32'd0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_32_int;
  logic        o_ov_flag;
  logic        o_nx_flag;

  int n_checks = 0;
  int n_errors = 0;

  fp2int_unit dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_32_a   (i_32_a),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_32_int (o_32_int),
    .o_ov_flag(o_ov_flag),
    .o_nx_flag(o_nx_flag)
  );

  always #5 i_clk = ~i_clk;

`ifdef FP2INT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: real-valued conversion via integer scaling of 1.mant * 2^e.
  function automatic void model(input logic [31:0] a, output logic [31:0] res,
                                output logic ov, output logic nx, output int lat);
    logic       sgn;
    int         ex, e, sh;
    longint     full, mag, rem, half, lim;
    sgn = a[31];
    ex  = int'(a[30:23]);
    e   = ex - 127;
    lat = (e >= 0 && e <= 30) ? e + 2 : 2;
    res = 32'd0; ov = 1'b0; nx = 1'b0;
    if (ex == 255) begin
      ov  = 1'b1;
      res = (a[22:0] != 0 || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return;
    end
    if (ex == 0) begin
      nx = (a[22:0] != 0);
      return;
    end
    full = longint'({1'b1, a[22:0]});
    rem  = 0;
    if (e >= 40) mag = 64'sd1 << 40;
    else if (e >= 23) mag = full << (e - 23);
    else if (e >= -1) begin
      sh   = 23 - e;
      mag  = full >> sh;
      rem  = full - (mag << sh);
      half = 64'sd1 << (sh - 1);
      if (RNE && (rem > half || (rem == half && mag[0]))) mag = mag + 1;
    end else begin
      mag = 0;
      rem = 1;
    end
    nx  = (rem != 0);
    lim = sgn ? 64'sd2147483648 : 64'sd2147483647;
    if (mag > lim) begin
      ov  = 1'b1;
      nx  = 1'b0;
      res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      res = sgn ? 32'(-mag) : 32'(mag);
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] e_res, input logic e_ov,
                        input logic e_nx, input int e_lat, input int hold);
    int lat;
    @(negedge i_clk);
    check_eq("ready_before_accept", 32'(o_ready), 32'd1);
    i_32_a  = a;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_32_a  = $urandom;
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check_eq($sformatf("latency[%08h]", a), 32'(lat), 32'(e_lat));
    check_eq($sformatf("result[%08h]", a), o_32_int, e_res);
    check_eq($sformatf("ov[%08h]", a), 32'(o_ov_flag), 32'(e_ov));
    check_eq($sformatf("nx[%08h]", a), 32'(o_nx_flag), 32'(e_nx));
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'($urandom % 2);
      i_32_a  = $urandom;
      @(posedge i_clk); #1;
      check_eq("hold_valid", 32'(o_valid), 32'd1);
      check_eq("hold_ready", 32'(o_ready), 32'd0);
      check_eq("hold_result", o_32_int, e_res);
      check_eq("hold_flags", {30'd0, o_ov_flag, o_nx_flag}, {30'd0, e_ov, e_nx});
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check_eq("valid_after_take", 32'(o_valid), 32'd0);
    check_eq("ready_after_take", 32'(o_ready), 32'd1);
  endtask

  task automatic run_model(input logic [31:0] a, input int hold);
    logic [31:0] r; logic ov, nx; int lat;
    model(a, r, ov, nx, lat);
    run_op(a, r, ov, nx, lat, hold);
  endtask

  initial begin
    logic [31:0] a;
    bit          seen;
    #3;
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_result", o_32_int, 32'd0);
    check_eq("rst_flags", {30'd0, o_ov_flag, o_nx_flag}, 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    run_op(32'h3FC0_0000, RNE ? 32'd2 : 32'd1, 1'b0, 1'b1, 2, 0);
    run_op(32'h4020_0000, 32'd2, 1'b0, 1'b1, 3, 0);
    run_op(32'h3F40_0000, RNE ? 32'd1 : 32'd0, 1'b0, 1'b1, 2, 0);
    run_op(32'h3F00_0000, 32'd0, 1'b0, 1'b1, 2, 0);
    run_op(32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b1, 8, 0);
    run_op(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 32, 0);
    run_op(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2, 0);
    run_op(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0);
    run_op(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2, 0);
    run_op(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0);
    run_op(32'h0000_0001, 32'd0, 1'b0, 1'b1, 2, 0);
    run_op(32'h8000_0000, 32'd0, 1'b0, 1'b0, 2, 0);
    run_op(32'hBF40_0000, RNE ? 32'hFFFF_FFFF : 32'd0, 1'b0, 1'b1, 2, 0);
    run_op(32'h3FC0_0000, RNE ? 32'd2 : 32'd1, 1'b0, 1'b1, 2, 5);

    // Reset in the middle of a long alignment
    @(negedge i_clk);
    i_32_a  = 32'h4EFF_FFFF;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #3;
    check_eq("midrst_ready", 32'(o_ready), 32'd1);
    check_eq("midrst_valid", 32'(o_valid), 32'd0);
    check_eq("midrst_result", o_32_int, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen  = 1'b0;
    repeat (35) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    check_eq("midrst_no_valid", 32'(seen), 32'd0);
    check_eq("midrst_idle", 32'(o_ready), 32'd1);
    run_op(32'h3F80_0000, 32'd1, 1'b0, 1'b0, 2, 0);

    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       a[30:23] = 8'd0;
        1:       a[30:23] = 8'd255;
        2:       a[30:23] = 8'($urandom_range(124, 127));
        3:       a[30:23] = 8'($urandom_range(155, 159));
        4:       a[30:23] = 8'($urandom);
        default: a[30:23] = 8'($urandom_range(126, 158));
      endcase
      run_model(a, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
